// File: rtl/udp_csum_pkg.sv
// Shared types and constants for the UDP checksum sequencer.
package udp_csum_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    FOLD1,
    FOLD2,
    DONE
  } state_e;

  // Byte lanes kept in the final word; byte0 sits in [31:24].
  localparam logic [31:0] MASK_TAIL1 = 32'hFF00_0000;
  localparam logic [31:0] MASK_TAIL2 = 32'hFFFF_0000;
  localparam logic [31:0] MASK_TAIL3 = 32'hFFFF_FF00;

  localparam logic [15:0] CSUM_ZERO_SUB = 16'hFFFF;

  function automatic logic [31:0] tail_mask(input logic [1:0] tail);
    logic [31:0] m;
    case (tail)
      2'd1:    m = MASK_TAIL1;
      2'd2:    m = MASK_TAIL2;
      2'd3:    m = MASK_TAIL3;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/udp_csum_fold16.sv
// Folds a 32-bit one's-complement partial sum to 16 bits with end-around carry.
module udp_csum_fold16 (
  input  logic [31:0] acc_i,
  output logic [15:0] fold_o
);

  logic [16:0] sum;

  assign sum    = {1'b0, acc_i[31:16]} + {1'b0, acc_i[15:0]};
  // hi+lo peaks at 0x1FFFE, so re-adding the carry cannot carry again
  assign fold_o = sum[15:0] + {15'h0, sum[16]};

endmodule

// File: rtl/udp_checksum_seq.sv
// Drains one packet from the checksum prefetch FIFO and produces the UDP checksum.
//
//   state | meaning
//   IDLE  | waiting for a command, cmd_rdy high
//   ACCUM | popping payload words into the 32-bit accumulator
//   FOLD1 | first end-around-carry fold
//   FOLD2 | second fold, checksum registered
//   DONE  | checksum held valid until consumer takes it
module udp_checksum_seq
  import udp_csum_pkg::*;
#(
  parameter int LEN_WIDTH = 16,
  parameter bit ZERO_SUB  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_vld,
  output logic                 cmd_rdy,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic [15:0]          cmd_seed,
  output logic                 fifo_rd_en,
  input  logic                 fifo_rd_vld,
  input  logic [31:0]          fifo_rd_data,
  output logic                 csum_vld,
  input  logic                 csum_rdy,
  output logic [15:0]          csum,
  output logic                 busy
);

  localparam int WCNT_W = LEN_WIDTH - 1;

  state_e              state_q;
  logic [WCNT_W-1:0]   words_q;
  logic [1:0]          tail_q;
  logic [31:0]         acc_q;
  logic                csum_vld_q;
  logic [15:0]         csum_q;

  logic [LEN_WIDTH:0]  len_p3;
  logic [WCNT_W-1:0]   words_d;
  logic                pop;
  logic                last_word;
  logic [31:0]         word_m;
  logic [31:0]         acc_d;
  logic [15:0]         fold;
  logic [15:0]         csum_d;

  assign len_p3    = {1'b0, cmd_len} + (LEN_WIDTH + 1)'(3);
  assign words_d   = WCNT_W'(len_p3 >> 2);

  assign fifo_rd_en = (state_q == ACCUM) && (words_q != '0);
  assign pop        = fifo_rd_en && fifo_rd_vld;
  assign last_word  = (words_q == WCNT_W'(1));
  assign word_m     = last_word ? (fifo_rd_data & tail_mask(tail_q)) : fifo_rd_data;
  assign acc_d      = acc_q + {16'h0, word_m[31:16]} + {16'h0, word_m[15:0]};

  udp_csum_fold16 u_fold (
    .acc_i  (acc_q),
    .fold_o (fold)
  );

  assign csum_d = (ZERO_SUB && (fold == 16'hFFFF)) ? CSUM_ZERO_SUB : ~fold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      words_q    <= '0;
      tail_q     <= 2'd0;
      acc_q      <= 32'h0;
      csum_vld_q <= 1'b0;
      csum_q     <= 16'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_vld) begin
            acc_q   <= {16'h0, cmd_seed};
            words_q <= words_d;
            tail_q  <= cmd_len[1:0];
            state_q <= (cmd_len == '0) ? FOLD1 : ACCUM;
          end
        end
        ACCUM: begin
          if (pop) begin
            acc_q   <= acc_d;
            words_q <= words_q - WCNT_W'(1);
            if (last_word) state_q <= FOLD1;
          end
        end
        FOLD1: begin
          acc_q   <= {16'h0, fold};
          state_q <= FOLD2;
        end
        FOLD2: begin
          acc_q      <= {16'h0, fold};
          csum_q     <= csum_d;
          csum_vld_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          if (csum_rdy) begin
            csum_vld_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_rdy  = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign csum_vld = csum_vld_q;
  assign csum     = csum_q;

endmodule

// File: tb/tb_udp_checksum_seq.sv
// Directed-vector bench for udp_checksum_seq with a queue-backed prefetch FIFO.
module tb_udp_checksum_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_vld = 1'b0;
  logic        cmd_rdy;
  logic [15:0] cmd_len = 16'h0;
  logic [15:0] cmd_seed = 16'h0;
  logic        fifo_rd_en;
  logic        fifo_rd_vld = 1'b0;
  logic [31:0] fifo_rd_data = 32'h0;
  logic        csum_vld;
  logic        csum_rdy = 1'b0;
  logic [15:0] csum;
  logic        busy;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  logic [31:0] fq[$];
  int pop_cnt  = 0;
  int en_seen  = 0;
  bit tog_mode = 1'b0;
  bit tog      = 1'b0;
  bit will_pop = 1'b0;

  udp_checksum_seq #(.LEN_WIDTH(16), .ZERO_SUB(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_vld      (cmd_vld),
    .cmd_rdy      (cmd_rdy),
    .cmd_len      (cmd_len),
    .cmd_seed     (cmd_seed),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_vld  (fifo_rd_vld),
    .fifo_rd_data (fifo_rd_data),
    .csum_vld     (csum_vld),
    .csum_rdy     (csum_rdy),
    .csum         (csum),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // FIFO model: retire the pop decided last half-cycle, then present the next head.
  always @(negedge clk) begin
    if (will_pop && !rst && fq.size() > 0) begin
      fq.delete(0);
      pop_cnt++;
    end
    if (fifo_rd_en) en_seen++;
    tog = ~tog;
    fifo_rd_vld  = (fq.size() > 0) && (!tog_mode || tog);
    fifo_rd_data = (fq.size() > 0) ? fq[0] : 32'hDEAD_BEEF;
    will_pop     = fifo_rd_en && fifo_rd_vld && !rst;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input string tag, input logic [15:0] len, input logic [15:0] seed);
    int n = 0;
    cmd_len  = len;
    cmd_seed = seed;
    cmd_vld  = 1'b1;
    while (!cmd_rdy && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_accept_timeout"}, 32'(n >= 100), 32'd0);
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
  endtask

  task automatic wait_csum(input string tag, input logic [15:0] exp, input int exp_lat);
    int lat = 0;
    do begin
      @(negedge clk);
      #1;
      lat++;
    end while (!csum_vld && lat < 300);
    chk({tag, "_vld"}, 32'(csum_vld), 32'd1);
    if (exp_lat > 0) chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_csum"}, 32'(csum), 32'(exp));
  endtask

  task automatic release_csum(input string tag);
    csum_rdy = 1'b1;
    @(posedge clk);
    #1;
    csum_rdy = 1'b0;
    step();
    chk({tag, "_vld_drop"}, 32'(csum_vld), 32'd0);
    chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
    chk({tag, "_cmd_rdy"}, 32'(cmd_rdy), 32'd1);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_csum_vld", 32'(csum_vld), 32'd0);
    chk("rst_csum", 32'(csum), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();

    // 0x4500 + 0x0030 = 0x4530 -> ~ = 0xBACF
    pop_cnt = 0;
    fq.push_back(32'h4500_0030);
    send_cmd("t1", 16'd4, 16'h0000);
    wait_csum("t1", 16'hBACF, 4);
    chk("t1_pops", 32'(pop_cnt), 32'd1);
    release_csum("t1");

    // tail 2 keeps 0x1234 -> ~ = 0xEDCB
    pop_cnt = 0;
    fq.push_back(32'h1234_ABCD);
    send_cmd("t2", 16'd2, 16'h0000);
    wait_csum("t2", 16'hEDCB, 4);
    chk("t2_pops", 32'(pop_cnt), 32'd1);
    release_csum("t2");

    // 0xFFFF + 0x0001 wraps to 0x0001 -> ~ = 0xFFFE
    fq.push_back(32'hFFFF_0001);
    send_cmd("t3", 16'd4, 16'h0000);
    wait_csum("t3", 16'hFFFE, 4);
    release_csum("t3");

    // empty payload: seed 0xFFFF inverts to 0x0000, substituted by 0xFFFF
    en_seen = 0;
    send_cmd("t4", 16'd0, 16'hFFFF);
    wait_csum("t4", 16'hFFFF, 3);
    chk("t4_no_rd_en", 32'(en_seen), 32'd0);
    release_csum("t4");

    // len 7, tail 3: 0x8000+0xFFFF+0xFFFF+0xAABB+0xCC00 = 0x3F6B9 -> 0xF6BC -> ~ = 0x0943
    pop_cnt = 0;
    fq.push_back(32'hFFFF_FFFF);
    fq.push_back(32'hAABB_CCDD);
    send_cmd("t7", 16'd7, 16'h8000);
    wait_csum("t7", 16'h0943, 5);
    chk("t7_pops", 32'(pop_cnt), 32'd2);
    release_csum("t7");

    // len 9 with stalls: 0x0102+0x0304+0x0506+0x0708+0x0900 = 0x1914 -> ~ = 0xE6EB
    tog_mode = 1'b1;
    pop_cnt  = 0;
    fq.push_back(32'h0102_0304);
    fq.push_back(32'h0506_0708);
    fq.push_back(32'h09AA_BBCC);
    send_cmd("t5", 16'd9, 16'h0000);
    wait_csum("t5", 16'hE6EB, 0);
    chk("t5_pops", 32'(pop_cnt), 32'd3);
    chk("t5_fifo_left", 32'(fq.size()), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_hold_csum", 32'(csum), 32'h0000_E6EB);
      chk("t5_hold_vld", 32'(csum_vld), 32'd1);
      chk("t5_hold_cmd_rdy", 32'(cmd_rdy), 32'd0);
    end
    release_csum("t5");
    tog_mode = 1'b0;

    // reset after the first of three pops
    begin
      int n = 0;
      pop_cnt = 0;
      fq.push_back(32'hFFFF_FFFF);
      fq.push_back(32'hFFFF_FFFF);
      fq.push_back(32'hFFFF_FFFF);
      send_cmd("t6a", 16'd12, 16'h5555);
      while (pop_cnt < 1 && n < 50) begin
        step();
        n++;
      end
      chk("t6_first_pop", 32'(pop_cnt), 32'd1);
      rst = 1'b1;
      step();
      chk("t6_rst_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
      chk("t6_rst_pops", 32'(pop_cnt), 32'd1);
      fq.delete();
      rst = 1'b0;
      step();
    end
    // seed 3 + 0x0001 + 0x0002 = 0x0006 -> ~ = 0xFFF9
    fq.push_back(32'h0001_0002);
    send_cmd("t6", 16'd4, 16'h0003);
    wait_csum("t6", 16'hFFF9, 4);
    release_csum("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
